// File: rtl/ram_dp_be.sv
// Simple dual-port synchronous RAM with per-byte write enables, configurable
// read-during-write behaviour, optional output register and post-reset clear.
// Read data is presented on a tri-state bus gated by oe.
module ram_dp_be #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int BYTE_WIDTH   = 8,
  parameter int OUT_REG      = 0,
  parameter int RDW_NEW      = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  output logic                                busy,
  input  logic                                wr_en,
  input  logic [ADDR_WIDTH-1:0]               wr_addr,
  input  logic [DATA_WIDTH-1:0]               wr_data,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    wr_be,
  input  logic                                rd_en,
  input  logic [ADDR_WIDTH-1:0]               rd_addr,
  input  logic                                oe,
  output logic [DATA_WIDTH-1:0]               data_out,
  output logic                                rd_valid
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_fwd;

  // Replace the enabled byte lanes of 'old_word' with those of 'new_word'.
  function automatic logic [DATA_WIDTH-1:0] lane_merge(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NB-1:0]         be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) begin
        res[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
      end else begin
        res[i*BYTE_WIDTH +: BYTE_WIDTH] = old_word[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    return res;
  endfunction

  // Request qualification and read-word selection, including same-address forwarding.
  always_comb begin
    wr_acc  = wr_en && !busy && !rst;
    rd_acc  = rd_en && !busy && !rst;
    rd_word = mem[rd_addr];
    rd_fwd  = rd_word;
    if ((RDW_NEW != 0) && wr_acc && (wr_addr == rd_addr)) begin
      rd_fwd = lane_merge(rd_word, wr_data, wr_be);
    end else begin
      rd_fwd = rd_word;
    end
  end

  // Clear sequencer: walks every address once after reset, busy tracks the CLEAR state.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_addr <= '0;
      if (CLEAR_ON_RST != 0) begin
        state <= CLEAR;
        busy  <= 1'b1;
      end else begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end else begin
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + ADDR_WIDTH'(1);
          if (clr_addr == {ADDR_WIDTH{1'b1}}) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= CLEAR;
            busy  <= 1'b1;
          end
        end
        IDLE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: clear writes zero, otherwise per-lane writes from the write port.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_addr] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (wr_acc && wr_be[i]) begin
          mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  generate
    if (OUT_REG == 0) begin : g_rd_direct
      // Single-stage read: rd_q/rd_valid capture the accepted read at the request edge.
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_q     <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= rd_acc;
          if (rd_acc) begin
            rd_q <= rd_fwd;
          end
        end
      end
    end else begin : g_rd_piped
      logic [DATA_WIDTH-1:0] pipe_q;
      logic                  pipe_v;
      // Two-stage read: an intermediate register delays data and valid by one cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          pipe_q   <= '0;
          pipe_v   <= 1'b0;
          rd_q     <= '0;
          rd_valid <= 1'b0;
        end else begin
          pipe_v   <= rd_acc;
          if (rd_acc) begin
            pipe_q <= rd_fwd;
          end
          rd_valid <= pipe_v;
          if (pipe_v) begin
            rd_q <= pipe_q;
          end
        end
      end
    end
  endgenerate

  assign data_out = oe ? rd_q : {DATA_WIDTH{1'bz}};

endmodule
